// File: rtl/mem_responder.sv
// mem_responder: word-addressed 32-bit data memory behind a req/ready
// handshake. Each request is captured in IDLE, held for LATENCY wait
// cycles, then completed with a single-cycle ready pulse. Only one request
// is serviced at a time.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous reset, active low
//   req    - request valid, sampled only in IDLE
//   we     - 1 = write, 0 = read (captured with req)
//   addr   - byte address (captured with req)
//   wdata  - write data (captured with req)
//   rdata  - read data, valid while ready=1 for a read
//   ready  - one-cycle completion pulse
//   busy   - high in WAIT and RESP
//   err    - qualifies ready: misaligned or out-of-range address
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for req; captures the request when req=1
// WAIT   | counting down LATENCY wait cycles, inputs ignored
// RESP   | ready=1 for one cycle, err reports captured address error
module mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam int         DEPTH    = 1 << ADDR_W;

  logic [1:0]        state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  logic [31:0]       mem [0:DEPTH-1];

  logic              addr_bad;
  logic              enter_resp;
  logic              op_we;
  logic              op_err;
  logic [ADDR_W-1:0] op_idx;
  logic [31:0]       op_wdata;

  // Misaligned, or any bit set above the word index: never aliases.
  always_comb begin
    addr_bad = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            state_nx = S_RESP;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nx = S_RESP;
        else             cnt_nx   = cnt - 4'd1;
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // With LATENCY=0, RESP is entered on the capture edge itself, so the
  // memory operation must use the live inputs rather than the capture regs.
  always_comb begin
    enter_resp = (state_nx == S_RESP);
    if (state == S_IDLE) begin
      op_we    = we;
      op_err   = addr_bad;
      op_idx   = addr[ADDR_W+1:2];
      op_wdata = wdata;
    end else begin
      op_we    = we_q;
      op_err   = err_q;
      op_idx   = addr_q;
      op_wdata = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata   <= 32'd0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == S_IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr[ADDR_W+1:2];
        wdata_q <= wdata;
        err_q   <= addr_bad;
      end
      ready <= enter_resp;
      busy  <= (state_nx != S_IDLE);
      err   <= enter_resp && op_err;
      if (enter_resp) begin
        if (op_err)      rdata <= 32'd0;
        else if (!op_we) rdata <= mem[op_idx];
      end
    end
  end

  // Storage has no reset; rst gating keeps a write from landing while the
  // block is held in reset.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && op_we && !op_err) begin
      mem[op_idx] <= op_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder.
// Two instances share clk/rst: u_dut2 (LATENCY=2) and u_dut0 (LATENCY=0).
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        req0, we0, req2, we2;
  logic [31:0] addr0, wdata0, addr2, wdata2;
  logic [31:0] rdata0, rdata2;
  logic        ready0, busy0, err0, ready2, busy2, err2;

  int errors = 0;
  int checks = 0;

  mem_responder #(.ADDR_W(16), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .ready(ready2), .busy(busy2), .err(err2)
  );

  mem_responder #(.ADDR_W(16), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req2 = r; we2 = w; addr2 = a; wdata2 = d;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? ready0 : ready2;
  endfunction

  // Issue one request from IDLE (called at posedge+1). lat counts cycles from
  // acceptance to the ready cycle; returns one cycle later, back in IDLE.
  task automatic txn(input int sel, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input bit scramble,
                     output logic [31:0] rdv, output logic e, output int lat);
    drive(sel, 1'b1, w, a, d);
    @(posedge clk); #1;
    if (scramble) drive(sel, 1'b0, w, 32'h80, 32'hFFFF_FFFF);
    else          drive(sel, 1'b0, w, a, d);
    lat = 1;
    while (!rdy(sel) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdv = (sel == 0) ? rdata0 : rdata2;
    e   = (sel == 0) ? err0 : err2;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          npulse;
    int          cyc;
    int          pc [3];
    logic [31:0] rd_b2b;
    logic [7:0]  pat;

    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready2}, 32'd0);
    check("rst_busy",  {31'd0, busy2},  32'd0);
    check("rst_err",   {31'd0, err2},   32'd0);
    check("rst_rdata", rdata2,          32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    txn(2, 1'b1, 32'h10, 32'h5555_AAAA, 1'b0, rd, e, lat);
    txn(2, 1'b1, 32'h80, 32'h8080_8080, 1'b0, rd, e, lat);
    txn(2, 1'b1, 32'h00, 32'h00C0_FFEE, 1'b0, rd, e, lat);

    // Write then read, LATENCY=2
    txn(2, 1'b1, 32'h40, 32'h1234_5678, 1'b0, rd, e, lat);
    check("wr40_lat", lat, 32'd3);
    check("wr40_err", {31'd0, e}, 32'd0);
    txn(2, 1'b0, 32'h40, 32'd0, 1'b0, rd, e, lat);
    check("rd40_lat",   lat, 32'd3);
    check("rd40_rdata", rd, 32'h1234_5678);
    check("rd40_err",   {31'd0, e}, 32'd0);

    // Reset in the middle of a write's WAIT phase
    drive(2, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    check("midrst_busy_before", {31'd0, busy2}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_busy",  {31'd0, busy2},  32'd0);
    check("midrst_ready", {31'd0, ready2}, 32'd0);
    check("midrst_rdata", rdata2,          32'd0);
    npulse = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ready2) npulse++;
    end
    @(negedge clk) rst = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready2) npulse++;
    end
    check("midrst_no_ready", npulse, 32'd0);
    txn(2, 1'b0, 32'h10, 32'd0, 1'b0, rd, e, lat);
    check("midrst_rd10", rd, 32'h5555_AAAA);

    // Input hold-off: addr/wdata scrambled during WAIT
    txn(2, 1'b1, 32'h44, 32'h0C0F_FEE0, 1'b1, rd, e, lat);
    check("hold_lat", lat, 32'd3);
    txn(2, 1'b0, 32'h44, 32'd0, 1'b0, rd, e, lat);
    check("hold_rd44", rd, 32'h0C0F_FEE0);
    txn(2, 1'b0, 32'h80, 32'd0, 1'b0, rd, e, lat);
    check("hold_rd80", rd, 32'h8080_8080);

    // Misaligned and out-of-range writes
    txn(2, 1'b1, 32'h42, 32'hBAD0_BAD0, 1'b0, rd, e, lat);
    check("mis_lat",   lat, 32'd3);
    check("mis_err",   {31'd0, e}, 32'd1);
    check("mis_rdata", rd, 32'd0);
    txn(2, 1'b0, 32'h40, 32'd0, 1'b0, rd, e, lat);
    check("mis_rd40",     rd, 32'h1234_5678);
    check("mis_rd40_err", {31'd0, e}, 32'd0);
    txn(2, 1'b1, 32'h0004_0000, 32'hBAD1_BAD1, 1'b0, rd, e, lat);
    check("oor_err",   {31'd0, e}, 32'd1);
    check("oor_rdata", rd, 32'd0);
    txn(2, 1'b0, 32'h00, 32'd0, 1'b0, rd, e, lat);
    check("oor_rd00", rd, 32'h00C0_FFEE);

    // Back-to-back with req held high
    drive(2, 1'b1, 1'b1, 32'h8, 32'h1);
    npulse = 0;
    cyc    = 0;
    rd_b2b = 32'hFFFF_FFFF;
    while (npulse < 3 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ready2) begin
        pc[npulse] = cyc;
        if (npulse == 1) rd_b2b = rdata2;
        npulse++;
        case (npulse)
          1:       drive(2, 1'b1, 1'b0, 32'h8, 32'h0);
          2:       drive(2, 1'b1, 1'b1, 32'h8, 32'h2);
          default: drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        endcase
      end
    end
    check("b2b_pulses", npulse, 32'd3);
    check("b2b_first",  pc[0], 32'd3);
    check("b2b_gap1",   pc[1] - pc[0], 32'd4);
    check("b2b_gap2",   pc[2] - pc[1], 32'd4);
    check("b2b_rdata",  rd_b2b, 32'h1);
    @(posedge clk); #1;
    txn(2, 1'b0, 32'h8, 32'd0, 1'b0, rd, e, lat);
    check("b2b_final", rd, 32'h2);

    // LATENCY=0 instance
    txn(0, 1'b1, 32'h0, 32'hA5A5_A5A5, 1'b0, rd, e, lat);
    check("l0_wr_lat", lat, 32'd1);
    check("l0_wr_err", {31'd0, e}, 32'd0);
    txn(0, 1'b0, 32'h0, 32'd0, 1'b0, rd, e, lat);
    check("l0_rd_lat",   lat, 32'd1);
    check("l0_rd_rdata", rd, 32'hA5A5_A5A5);
    drive(0, 1'b1, 1'b0, 32'h0, 32'd0);
    pat = 8'd0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      pat[i] = ready0;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'd0);
    check("l0_held_pattern", {24'd0, pat}, 32'h55);
    check("l0_held_rdata",   rdata0, 32'hA5A5_A5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
